vga_level_overlay: RTL

- Avalon-ST pixel stage between the face image generator and the VGA output module; all three carry 30-bit RGB pixels.
- Tracks the x/y position of every pixel and replaces pixels inside a horizontal bar with a solid colour; bar length comes from a level input.
- Decouples both handshakes with a registered output and a one-entry skid buffer, so full throughput holds under backpressure.
- Flags frames whose packet markers disagree with the 640x480 pixel count.

---
 rtl/vga_level_overlay.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_level_overlay.sv
// vga_level_overlay: Avalon-ST pixel stage that tracks pixel position and
// paints a solid horizontal bar whose length follows a per-frame level.
//   clk, reset                 : clock, synchronous active-high reset
//   level                      : bar length control, bar covers x < 2*level
//   in_*                       : sink pixel stream {R,G,B} with SOP/EOP markers
//   out_*                      : source pixel stream, registered outputs
//   frame_error                : sticky flag for marker/pixel-count mismatch
module vga_level_overlay #(
    parameter int unsigned Width     = 640,
    parameter int unsigned Height    = 480,
    parameter int unsigned BarY0     = 440,
    parameter int unsigned BarH      = 16,
    parameter logic [29:0] BarColour = {10'h3FF, 10'h3FC, 10'h000}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  level,
    input  logic [29:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [29:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_error
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned DW = 30;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [7:0]    r_level_q;
    logic          r_synced;
    logic          r_frame_error;

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_sop;
    logic          r_out_eop;

    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;
    logic          r_skid_sop;
    logic          r_skid_eop;

    logic          w_accept;
    logic          w_emit;
    logic          w_out_free;
    logic [XW-1:0] w_pos_x;
    logic [YW-1:0] w_pos_y;
    logic [7:0]    w_level;
    logic          w_in_bar;
    logic [DW-1:0] w_pix;
    logic          w_last_x;
    logic          w_last_pos;
    logic          w_err;

    // Ready depends only on skid occupancy, never on out_ready.
    assign in_ready          = ~r_skid_valid & ~reset;
    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign frame_error       = r_frame_error;

    // Position, overlay decision and marker check for the pixel on the sink.
    always_comb begin
        w_accept   = in_valid & in_ready;
        w_emit     = r_out_valid & out_ready;
        w_out_free = ~r_out_valid | out_ready;
        // SOP forces (0,0) so a corrupted stream resyncs on the next frame.
        w_pos_x    = in_startofpacket ? '0 : r_x;
        w_pos_y    = in_startofpacket ? '0 : r_y;
        // SOP pixel already uses the level being latched this cycle.
        w_level    = in_startofpacket ? level : r_level_q;
        w_in_bar   = (w_pos_y >= YW'(BarY0)) &&
                     (w_pos_y <= YW'(BarY0 + BarH - 1)) &&
                     (w_pos_x < XW'({w_level, 1'b0}));
        w_pix      = w_in_bar ? BarColour : in_data;
        w_last_x   = (w_pos_x == XW'(Width - 1));
        w_last_pos = w_last_x && (w_pos_y == YW'(Height - 1));
        // Checks are armed once the first SOP after reset has been seen.
        w_err      = ((r_synced | in_startofpacket) && (in_endofpacket != w_last_pos)) ||
                     (in_startofpacket && r_synced && ((r_x != '0) || (r_y != '0)));
    end

    // Position counters, level latch and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_level_q     <= '0;
            r_synced      <= 1'b0;
            r_frame_error <= 1'b0;
        end else if (w_accept) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_pos ? '0 : w_pos_y + YW'(1);
            end else begin
                r_x <= w_pos_x + XW'(1);
                r_y <= w_pos_y;
            end
            if (in_startofpacket) begin
                r_level_q <= level;
                r_synced  <= 1'b1;
            end
            if (w_err) begin
                r_frame_error <= 1'b1;
            end
        end
    end

    // Output register plus one-entry skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sop   <= 1'b0;
            r_skid_eop   <= 1'b0;
        end else if (w_accept) begin
            // Skid is empty whenever a pixel is accepted.
            if (w_out_free) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pix;
                r_out_sop   <= in_startofpacket;
                r_out_eop   <= in_endofpacket;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_pix;
                r_skid_sop   <= in_startofpacket;
                r_skid_eop   <= in_endofpacket;
            end
        end else if (w_emit) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_sop    <= r_skid_sop;
                r_out_eop    <= r_skid_eop;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
